spi_bus_arbiter: RTL and testbench

- Shares the single spi_master byte engine between two transaction controllers: client 0 (flash read controller) and client 1 (flash write/erase controller).
- Each client holds its request high for a whole multi-byte command (CMD + ADDR + DATA) and sees one trans_done pulse per byte.
- The arbiter grants one client at a time for a full transaction and breaks simultaneous requests round-robin.
- It inserts an idle gap between transactions so the master deasserts chip-select, and it runs a per-byte watchdog.

---
 rtl/spi_bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_arbiter.sv
// Two-client arbiter in front of a single spi_master byte engine: whole-transaction grants,
// round-robin tie break, forced idle gap between owners and a per-byte watchdog.
module spi_bus_arbiter #(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       c0_trans_req,
  input  logic [7:0] c0_tx_dout,
  output logic       c0_trans_done,
  output logic       c0_grant,
  input  logic       c1_trans_req,
  input  logic [7:0] c1_tx_dout,
  output logic       c1_trans_done,
  output logic       c1_grant,
  output logic [7:0] rx_dout,
  output logic       m_trans_req,
  output logic [7:0] m_tx_dout,
  input  logic [7:0] m_rx_din,
  input  logic       m_trans_done,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GapLast  = 8'(GAP_CYC - 1);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1, StGap} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        lock0_q, lock0_d;
  logic        lock1_q, lock1_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] wdog_q, wdog_d;

  logic elig0, elig1, wdog_expire;

  assign elig0       = c0_trans_req & ~lock0_q;
  assign elig1       = c1_trans_req & ~lock1_q;
  assign wdog_expire = (wdog_q == WdogLast) & ~m_trans_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      lock0_q      <= 1'b0;
      lock1_q      <= 1'b0;
      gap_q        <= 8'd0;
      wdog_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock0_q      <= lock0_d;
      lock1_q      <= lock1_d;
      gap_q        <= gap_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (elig0 && elig1) begin
          state_d = last_grant_q ? StGrant0 : StGrant1;
        end else if (elig0) begin
          state_d = StGrant0;
        end else if (elig1) begin
          state_d = StGrant1;
        end
      end
      StGrant0: if (!c0_trans_req || wdog_expire) state_d = StGap;
      StGrant1: if (!c1_trans_req || wdog_expire) state_d = StGap;
      StGap:    if (gap_q == GapLast) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Lock flags clear as soon as the owning client is seen with its request low.
  always_comb begin
    last_grant_d = last_grant_q;
    lock0_d      = lock0_q & c0_trans_req;
    lock1_d      = lock1_q & c1_trans_req;
    gap_d        = 8'd0;
    wdog_d       = 16'd0;
    unique case (state_q)
      StGrant0: begin
        if (!c0_trans_req) begin
          last_grant_d = 1'b0;
        end else if (wdog_expire) begin
          last_grant_d = 1'b0;
          lock0_d      = 1'b1;
        end else if (!m_trans_done) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StGrant1: begin
        if (!c1_trans_req) begin
          last_grant_d = 1'b1;
        end else if (wdog_expire) begin
          last_grant_d = 1'b1;
          lock1_d      = 1'b1;
        end else if (!m_trans_done) begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StGap:   gap_d = (gap_q == GapLast) ? 8'd0 : gap_q + 8'd1;
      default: ;
    endcase
  end

  assign rx_dout = m_rx_din;

  always_comb begin
    c0_grant      = 1'b0;
    c1_grant      = 1'b0;
    c0_trans_done = 1'b0;
    c1_trans_done = 1'b0;
    m_trans_req   = 1'b0;
    m_tx_dout     = 8'h00;
    timeout_err   = 1'b0;
    busy          = (state_q != StIdle);
    unique case (state_q)
      StGrant0: begin
        c0_grant      = 1'b1;
        m_trans_req   = c0_trans_req;
        m_tx_dout     = c0_tx_dout;
        c0_trans_done = m_trans_done;
        timeout_err   = c0_trans_req & wdog_expire;
      end
      StGrant1: begin
        c1_grant      = 1'b1;
        m_trans_req   = c1_trans_req;
        m_tx_dout     = c1_tx_dout;
        c1_trans_done = m_trans_done;
        timeout_err   = c1_trans_req & wdog_expire;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with GAP_CYC=2, TIMEOUT=16.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       c0_req, c1_req;
  logic [7:0] c0_tx, c1_tx;
  logic       c0_td, c1_td, c0_grant, c1_grant;
  logic [7:0] rx_dout, m_tx, m_rx;
  logic       m_req, m_done, busy, timeout_err;

  int checks = 0;
  int passed = 0;
  int n0 = 0;
  int n1 = 0;
  logic [7:0] bytes [8] = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h5A, 8'hA5, 8'hFF, 8'h00};

  spi_bus_arbiter #(.GAP_CYC(2), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .c0_trans_req (c0_req),
    .c0_tx_dout   (c0_tx),
    .c0_trans_done(c0_td),
    .c0_grant     (c0_grant),
    .c1_trans_req (c1_req),
    .c1_tx_dout   (c1_tx),
    .c1_trans_done(c1_td),
    .c1_grant     (c1_grant),
    .rx_dout      (rx_dout),
    .m_trans_req  (m_req),
    .m_tx_dout    (m_tx),
    .m_rx_din     (m_rx),
    .m_trans_done (m_done),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (c0_td) n0++;
    if (c1_td) n1++;
  end

  initial begin
    #1000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; c0_req = 0; c1_req = 0; c0_tx = 0; c1_tx = 0; m_rx = 0; m_done = 0;
    tick();
    tick();
    check("rst busy", 16'(busy), 0);
    check("rst m_req", 16'(m_req), 0);
    rst = 1'b0;
    #1;
    check("idle grants", {c0_grant, c1_grant}, 0);
    check("idle m_tx", 16'(m_tx), 0);
    check("idle timeout_err", 16'(timeout_err), 0);

    // 1: single client 0 transaction
    c0_req = 1; c0_tx = 8'h03;
    #1;
    check("t1 no grant before edge", 16'(c0_grant), 0);
    check("t1 m_req before grant", 16'(m_req), 0);
    tick();
    check("t1 c0_grant", 16'(c0_grant), 1);
    check("t1 c1_grant", 16'(c1_grant), 0);
    check("t1 m_tx cmd", 16'(m_tx), 16'h03);
    check("t1 m_req", 16'(m_req), 1);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      c0_tx = bytes[i]; m_rx = 8'hA0 + 8'(i); m_done = 1;
      #1;
      check("t1 m_tx byte", 16'(m_tx), 16'(bytes[i]));
      check("t1 c0_td", 16'(c0_td), 1);
      check("t1 rx_dout", 16'(rx_dout), 16'(8'hA0 + 8'(i)));
      tick();
      m_done = 0;
      tick();
    end
    check("t1 c0 pulses", 16'(n0), 8);
    check("t1 c1 pulses", 16'(n1), 0);
    c0_req = 0;
    #1;
    check("t1 m_req drop", 16'(m_req), 0);
    tick();
    check("t1 gap grant low", 16'(c0_grant), 0);
    check("t1 gap busy0", 16'(busy), 1);
    tick();
    check("t1 gap busy1", 16'(busy), 1);
    tick();
    check("t1 idle busy", 16'(busy), 0);

    // 2: ties after reset, then round-robin alternation
    do_reset();
    c0_req = 1; c1_req = 1; c0_tx = 8'h11; c1_tx = 8'h22;
    tick();
    check("t2 first tie", {c0_grant, c1_grant}, 16'b10);
    check("t2 m_tx c0", 16'(m_tx), 16'h11);
    c0_req = 0;
    repeat (3) tick();
    check("t2 c1 not yet", 16'(c1_grant), 0);
    tick();
    check("t2 c1 granted", {c0_grant, c1_grant}, 16'b01);
    check("t2 m_tx c1", 16'(m_tx), 16'h22);
    c1_req = 0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      c0_req = 1; c1_req = 1;
      tick();
      check("t2 rr tie", {c0_grant, c1_grant}, (k % 2 == 0) ? 16'b10 : 16'b01);
      c0_req = 0; c1_req = 0;
      repeat (3) tick();
      check("t2 rr idle", 16'(busy), 0);
    end

    // 3: client 1 arrives mid-transaction, no preemption
    c0_req = 1; c0_tx = 8'h03;
    tick();
    check("t3 c0_grant", 16'(c0_grant), 1);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        c1_req = 1; c1_tx = 8'hEE;
      end
      c0_tx = bytes[i]; m_done = 1;
      #1;
      check("t3 m_tx c0 only", 16'(m_tx), 16'(bytes[i]));
      check("t3 no c1_grant", 16'(c1_grant), 0);
      check("t3 no c1_td", 16'(c1_td), 0);
      tick();
      m_done = 0;
      tick();
    end
    c0_req = 0;
    repeat (3) tick();
    check("t3 c1 waits gap", 16'(c1_grant), 0);
    tick();
    check("t3 c1 granted", 16'(c1_grant), 1);
    check("t3 m_tx c1", 16'(m_tx), 16'hEE);
    c1_req = 0;
    repeat (3) tick();

    // 4: watchdog release and lockout
    c0_req = 1; c0_tx = 8'h77;
    tick();
    check("t4 c0_grant", 16'(c0_grant), 1);
    c1_req = 1;
    repeat (14) tick();
    check("t4 no early timeout", 16'(timeout_err), 0);
    tick();
    check("t4 timeout pulse", 16'(timeout_err), 1);
    check("t4 grant held", 16'(c0_grant), 1);
    tick();
    check("t4 grant dropped", 16'(c0_grant), 0);
    check("t4 pulse ends", 16'(timeout_err), 0);
    tick();
    tick();
    check("t4 idle no grant", {c0_grant, c1_grant}, 0);
    tick();
    check("t4 c1 after gap", {c0_grant, c1_grant}, 16'b01);
    c1_req = 0;
    repeat (3) tick();
    tick();
    check("t4 c0 locked", {c0_grant, busy}, 0);
    c0_req = 0;
    tick();
    c0_req = 1;
    tick();
    check("t4 c0 regranted", 16'(c0_grant), 1);
    c0_req = 0;
    repeat (3) tick();

    // 5: stray trans_done handling
    m_done = 1;
    #1;
    check("t5 idle stray", {c0_td, c1_td}, 0);
    tick();
    m_done = 0;
    c0_req = 1;
    tick();
    check("t5 c0_grant", 16'(c0_grant), 1);
    m_done = 1; c0_req = 0;
    #1;
    check("t5 done on drop", 16'(c0_td), 1);
    check("t5 m_req on drop", 16'(m_req), 0);
    tick();
    check("t5 gap stray", {c0_td, c1_td}, 0);
    tick();
    m_done = 0;
    tick();
    check("t5 idle", 16'(busy), 0);

    // 6: asynchronous reset mid-transaction
    c1_req = 1; c1_tx = 8'h9C;
    tick();
    for (int i = 0; i < 4; i++) begin
      m_done = 1;
      tick();
      m_done = 0;
      tick();
    end
    check("t6 pre-reset m_req", 16'(m_req), 1);
    #1;
    rst = 1;
    #1;
    check("t6 async m_req", 16'(m_req), 0);
    check("t6 async grant", 16'(c1_grant), 0);
    check("t6 async busy", 16'(busy), 0);
    c0_req = 1;
    tick();
    rst = 0;
    tick();
    check("t6 tie after reset", {c0_grant, c1_grant}, 16'b10);
    c0_req = 0; c1_req = 0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
